// File: rtl/matrix_frame_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_frame_writer_pkg
//  Description : Shared types for the matrix frame writer. Holds the command
//                opcode encoding, the writer state encoding, the row and
//                column widths, and a row-range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_frame_writer_pkg;

   localparam int c_row_w = 8;   // bits per frame row (one bit per pixel)
   localparam int c_x_w   = 3;   // column index width
   localparam int c_adr_w = 8;   // frame-RAM address width

   typedef enum logic [1:0] {
      OP_SET    = 2'b00,
      OP_CLR    = 2'b01,
      OP_TOG    = 2'b10,
      OP_CLRALL = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      CLR  = 3'd4
   } state_t;

   // True when y is a frame-RAM address that holds a matrix row.
   function automatic logic y_in_range(input logic [c_adr_w-1:0] y,
                                       input logic [c_adr_w-1:0] lo,
                                       input logic [c_adr_w-1:0] hi);
      return (y >= lo) && (y <= hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_frame_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_frame_writer_if
//  Description : Command handshake plus frame-RAM port of the frame writer.
//                slave  : the writer (accepts commands, drives the RAM port)
//                master : the environment (issues commands, returns RAM data)
//  Ports       : cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y, mem_addr/mem_we/
//                mem_wdata/mem_rdata, done/err status pulses
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_frame_writer_if;
   import matrix_frame_writer_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [c_x_w-1:0]     cmd_x;
   logic [c_adr_w-1:0]   cmd_y;
   logic [c_adr_w-1:0]   mem_addr;
   logic                 mem_we;
   logic [c_row_w-1:0]   mem_wdata;
   logic [c_row_w-1:0]   mem_rdata;
   logic                 done;
   logic                 err;

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y, mem_rdata,
      input  cmd_ready, mem_addr, mem_we, mem_wdata, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y, mem_rdata,
      output cmd_ready, mem_addr, mem_we, mem_wdata, done, err
   );

endinterface
`default_nettype wire

// File: rtl/matrix_frame_writer_row_modify.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_row_modify
//  Description : Purely combinational row update. Sets, clears or inverts
//                bit i_x of i_row according to i_op. Bit x = 1 means the
//                pixel is lit; any column inversion is done by the scanner.
//  Ports       : i_row (current row), i_x (column), i_op (opcode),
//                o_row (updated row)
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_row_modify
   import matrix_frame_writer_pkg::*;
(
   input  logic [c_row_w-1:0] i_row,
   input  logic [c_x_w-1:0]   i_x,
   input  op_t                i_op,
   output logic [c_row_w-1:0] o_row
);

   logic [c_row_w-1:0] w_mask;

   always_comb begin
      w_mask = c_row_w'(1) << i_x;
      o_row  = i_row;
      case (i_op)
         OP_SET:    o_row = i_row | w_mask;
         OP_CLR:    o_row = i_row & ~w_mask;
         OP_TOG:    o_row = i_row ^ w_mask;
         OP_CLRALL: o_row = '0;
         default:   o_row = i_row;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/matrix_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_frame_writer
//  Description : Pixel writer for the LED-matrix frame RAM shared with the
//                scanner. Pixel ops do a read-modify-write of one row
//                (IDLE->RD->WAIT->WR); clear-frame writes 0x00 to every row
//                address ROW_START..ROW_END, one per cycle. All outputs are
//                registered.
//  Ports       : clk, reset (sync, active-high), bus (slave modport:
//                command handshake, RAM port, done/err pulses)
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_frame_writer
   import matrix_frame_writer_pkg::*;
#(
   parameter int ROW_START = 1,
   parameter int ROW_END   = 8
)(
   input  logic                    clk,
   input  logic                    reset,
   matrix_frame_writer_if.slave    bus
);

   localparam logic [c_adr_w-1:0] c_row_start = c_adr_w'(ROW_START);
   localparam logic [c_adr_w-1:0] c_row_end   = c_adr_w'(ROW_END);

   state_t               r_state;
   op_t                  r_op;
   logic [c_x_w-1:0]     r_x;
   logic [c_adr_w-1:0]   r_addr;    // latched y for pixel ops, counter in CLR
   logic                 r_we;
   logic [c_row_w-1:0]   r_wdata;
   logic                 r_ready;
   logic                 r_done;
   logic                 r_err;

   op_t                  w_cmd_op;
   logic                 w_accept;
   logic [c_row_w-1:0]   w_new_row;
   logic [c_adr_w-1:0]   w_addr_inc;

   assign w_cmd_op   = op_t'(bus.cmd_op);
   assign w_accept   = r_ready && bus.cmd_valid && (r_state == IDLE);
   assign w_addr_inc = r_addr + c_adr_w'(1);

   // mem_rdata during WAIT is the row addressed in RD; the updated row is
   // registered into r_wdata at the WAIT->WR edge.
   matrix_row_modify u_row_modify (
      .i_row (bus.mem_rdata),
      .i_x   (r_x),
      .i_op  (r_op),
      .o_row (w_new_row)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_op    <= OP_SET;
         r_x     <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_ready <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               r_we    <= 1'b0;
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_op <= w_cmd_op;
                  r_x  <= bus.cmd_x;
                  if (w_cmd_op == OP_CLRALL) begin
                     r_state <= CLR;
                     r_ready <= 1'b0;
                     r_addr  <= c_row_start;
                     r_we    <= 1'b1;
                     r_wdata <= '0;
                     r_done  <= (c_row_start == c_row_end);
                  end else if (y_in_range(bus.cmd_y, c_row_start, c_row_end)) begin
                     r_state <= RD;
                     r_ready <= 1'b0;
                     r_addr  <= bus.cmd_y;
                  end else begin
                     // Out-of-range row: no RAM access, mem_addr keeps its
                     // value and the writer stays ready.
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end
               end
            end
            RD: begin
               r_state <= WAIT;
            end
            WAIT: begin
               r_state <= WR;
               r_we    <= 1'b1;
               r_wdata <= w_new_row;
               r_done  <= 1'b1;
            end
            WR: begin
               r_state <= IDLE;
               r_we    <= 1'b0;
               r_ready <= 1'b1;
            end
            CLR: begin
               // Equality stop at ROW_END; ROW_END <= 255 so the counter
               // never needs to wrap.
               if (r_addr == c_row_end) begin
                  r_state <= IDLE;
                  r_we    <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_addr <= w_addr_inc;
                  r_done <= (w_addr_inc == c_row_end);
               end
            end
            default: begin
               r_state <= IDLE;
               r_we    <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cmd_ready = r_ready;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_we    = r_we;
   assign bus.mem_wdata = r_wdata;
   assign bus.done      = r_done;
   assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_frame_writer
//  Description : Self-checking bench for matrix_frame_writer. Contains a
//                synchronous frame-RAM model (one-cycle read latency, with a
//                backdoor preload port) and a shadow frame used as the
//                reference for expected row contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_frame_writer;
   import matrix_frame_writer_pkg::*;

   localparam int c_row_start = 1;
   localparam int c_row_end   = 8;
   localparam int c_nrows     = c_row_end - c_row_start + 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   matrix_frame_writer_if bus ();

   matrix_frame_writer #(
      .ROW_START (c_row_start),
      .ROW_END   (c_row_end)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- frame RAM model + shadow frame ----------------
   logic [7:0] ram   [0:255];
   logic [7:0] model [0:255];
   logic       bd_we;
   logic [7:0] bd_addr;
   logic [7:0] bd_data;
   int         cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mem_we)  ram[bus.mem_addr] <= bus.mem_wdata;
      else if (bd_we)  ram[bd_addr]      <= bd_data;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int total = 0;
   int bad   = 0;

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] apply(input logic [7:0] row, input logic [2:0] x,
                                        input logic [1:0] op);
      logic [7:0] bitv;
      bitv = 8'(1 << x);
      case (op)
         2'b00:   return row | bitv;
         2'b01:   return row & ~bitv;
         2'b10:   return row ^ bitv;
         default: return 8'h00;
      endcase
   endfunction

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
      model[a] = d;
   endtask

   task automatic wait_ready(output bit ok);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      ok = bus.cmd_ready;
      if (!ok) check("ready_timeout", 0, 1);
   endtask

   // One command; the expected cycle-by-cycle behaviour follows from the op:
   // pixel in range -> write on cycle 3, out of range -> err/done on cycle 1,
   // clear frame -> one zero write per row address.
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] x, input logic [7:0] y,
                          input bit exp_err, input logic [7:0] exp_data);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      if (op == 2'b11) begin
         for (int k = 0; k < c_nrows; k++) begin
            @(negedge clk);
            check("clr_we",    int'(bus.mem_we),    1);
            check("clr_addr",  int'(bus.mem_addr),  c_row_start + k);
            check("clr_data",  int'(bus.mem_wdata), 0);
            check("clr_done",  int'(bus.done),      int'(k == c_nrows - 1));
            check("clr_ready", int'(bus.cmd_ready), 0);
         end
      end else if (exp_err) begin
         @(negedge clk);
         check("oor_we",    int'(bus.mem_we),    0);
         check("oor_err",   int'(bus.err),       1);
         check("oor_done",  int'(bus.done),      1);
         check("oor_ready", int'(bus.cmd_ready), 1);
      end else begin
         for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("pix_we",    int'(bus.mem_we),    int'(k == 3));
            check("pix_addr",  int'(bus.mem_addr),  int'(y));
            check("pix_done",  int'(bus.done),      int'(k == 3));
            check("pix_err",   int'(bus.err),       0);
            check("pix_ready", int'(bus.cmd_ready), 0);
            if (k == 3) check("pix_data", int'(bus.mem_wdata), int'(exp_data));
         end
      end
      @(negedge clk);
      check("end_ready", int'(bus.cmd_ready), 1);
      check("end_we",    int'(bus.mem_we),    0);
      check("end_done",  int'(bus.done),      0);
      check("end_err",   int'(bus.err),       0);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [2:0] x;
      logic [7:0] y;
      bit         pre;
      logic [7:0] init;
      bit         exp_err;
      logic [7:0] exp_data;
   } vec_t;

   vec_t       vecs [8];
   logic [1:0] rop;
   logic [2:0] rx;
   logic [7:0] ry;
   logic [7:0] ed;
   bit         inr;
   bit         ok;
   bit         hs;
   int         idx;
   int         wr_cnt;
   int         overlap;
   int         hs_cyc [3];
   logic [1:0] bb_op [3];
   logic [2:0] bb_x  [3];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_x = '0; bus.cmd_y = '0;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0;

      vecs[0] = '{2'b00, 3'd5, 8'd3, 1'b1, 8'h00, 1'b0, 8'h20};
      vecs[1] = '{2'b10, 3'd0, 8'd8, 1'b1, 8'hFF, 1'b0, 8'hFE};
      vecs[2] = '{2'b01, 3'd7, 8'd8, 1'b0, 8'h00, 1'b0, 8'h7E};
      vecs[3] = '{2'b00, 3'd2, 8'd0, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[4] = '{2'b00, 3'd2, 8'd9, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[5] = '{2'b10, 3'd3, 8'd1, 1'b1, 8'h08, 1'b0, 8'h00};
      vecs[6] = '{2'b01, 3'd0, 8'd5, 1'b1, 8'h81, 1'b0, 8'h80};
      vecs[7] = '{2'b00, 3'd7, 8'd8, 1'b1, 8'h7F, 1'b0, 8'hFF};

      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      check("rst_addr",  int'(bus.mem_addr),  0);
      check("rst_we",    int'(bus.mem_we),    0);
      check("rst_wdata", int'(bus.mem_wdata), 0);
      check("rst_done",  int'(bus.done),      0);
      check("rst_err",   int'(bus.err),       0);
      for (int a = 0; a < 16; a++) preload(8'(a), 8'($urandom_range(0, 255)));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", int'(bus.cmd_ready), 1);

      // ---------------- table vectors ----------------
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].pre) preload(vecs[i].y, vecs[i].init);
         run_cmd(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].exp_err, vecs[i].exp_data);
         if (!vecs[i].exp_err) model[vecs[i].y] = vecs[i].exp_data;
      end

      // ---------------- clear frame ----------------
      run_cmd(2'b11, 3'd6, 8'd200, 1'b0, 8'h00);
      for (int a = c_row_start; a <= c_row_end; a++) begin
         model[a] = 8'h00;
         check("clr_row", int'(ram[a]), 0);
      end

      // ---------------- randomized commands vs shadow frame ----------------
      for (int i = 0; i < 40; i++) begin
         rop = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
         rx  = 3'($urandom_range(0, 7));
         ry  = 8'($urandom_range(0, 10));
         inr = (int'(ry) >= c_row_start) && (int'(ry) <= c_row_end);
         if (rop == 2'b11) begin
            run_cmd(rop, rx, ry, 1'b0, 8'h00);
            for (int a = c_row_start; a <= c_row_end; a++) model[a] = 8'h00;
         end else begin
            ed = apply(model[ry], rx, rop);
            run_cmd(rop, rx, ry, !inr, ed);
            if (inr) model[ry] = ed;
         end
      end

      // ---------------- cmd_valid held across three commands ----------------
      bb_op[0] = 2'b00; bb_x[0] = 3'd1;
      bb_op[1] = 2'b10; bb_x[1] = 3'd1;
      bb_op[2] = 2'b00; bb_x[2] = 3'd7;
      wait_ready(ok);
      idx = 0; wr_cnt = 0; overlap = 0;
      bus.cmd_valid = 1'b1; bus.cmd_op = bb_op[0]; bus.cmd_x = bb_x[0]; bus.cmd_y = 8'd2;
      for (int g = 0; g < 60 && idx < 3; g++) begin
         if (bus.mem_we) wr_cnt++;
         if (bus.mem_we && bus.cmd_ready) overlap++;
         hs = bus.cmd_ready;
         @(posedge clk); #1;
         if (hs) begin
            hs_cyc[idx] = cyc;
            model[2] = apply(model[2], bb_x[idx], bb_op[idx]);
            idx++;
            if (idx < 3) begin
               bus.cmd_op = bb_op[idx]; bus.cmd_x = bb_x[idx];
            end else begin
               bus.cmd_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      for (int g = 0; g < 8; g++) begin
         if (bus.mem_we) wr_cnt++;
         if (bus.mem_we && bus.cmd_ready) overlap++;
         @(negedge clk);
      end
      check("bb_handshakes", idx, 3);
      check("bb_writes", wr_cnt, 3);
      check("bb_overlap", overlap, 0);
      if (idx == 3) begin
         check("bb_gap1", hs_cyc[1] - hs_cyc[0], 4);
         check("bb_gap2", hs_cyc[2] - hs_cyc[1], 4);
      end
      check("bb_row", int'(ram[2]), int'(model[2]));

      // ---------------- reset in the 4th CLR cycle ----------------
      for (int a = c_row_start; a <= c_row_end; a++) preload(8'(a), 8'(8'hA0 | a));
      wait_ready(ok);
      bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_x = '0; bus.cmd_y = '0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_pre_we",   int'(bus.mem_we),   1);
      check("abort_pre_addr", int'(bus.mem_addr), 4);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_we",   int'(bus.mem_we),   0);
      check("abort_done", int'(bus.done),     0);
      check("abort_addr", int'(bus.mem_addr), 0);
      @(negedge clk);
      check("abort_done2", int'(bus.done), 0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready", int'(bus.cmd_ready), 1);
      check("abort_done3", int'(bus.done),      0);
      for (int a = 1; a <= 4; a++) model[a] = 8'h00;
      for (int a = c_row_start; a <= c_row_end; a++)
         check("abort_row", int'(ram[a]), int'(model[a]));

      // ---------------- final frame contents ----------------
      for (int a = 0; a < 16; a++) check("frame", int'(ram[a]), int'(model[a]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
